id_ex_operand_stage: RTL
========================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register with EX-stage operand forwarding and load-use hazard detection.
//  Captures decoded operands and control from ID and forwards EX/MEM and MEM/WB results.
//  Drives the two ALU operand inputs (mux_1_out_alu_in, mux_ex_out_alu_in) and ALUOp.
//  Carries store data and downstream control into EX/MEM.
// PARAMETERS
//  XLEN        64  datapath width
//  REG_ADDR_W  5   register index width
// PORTS
//  clk                input   1           rising-edge clock
//  reset              input   1           synchronous, active-high reset
//  id_valid           input   1           ID holds a real instruction
//  id_rs1_data        input   XLEN        register-file read data, rs1
//  id_rs2_data        input   XLEN        register-file read data, rs2
//  id_imm             input   XLEN        sign-extended immediate
//  id_rs1, id_rs2     input   REG_ADDR_W  source register indices
//  id_rd              input   REG_ADDR_W  destination register index
//  id_alu_op          input   4           ALU operation ({ainv,binv,sel[1:0]})
//  id_alu_src         input   1           1 = operand B is immediate
//  id_ctrl            input   5           {branch,mem_to_reg,mem_write,mem_read,reg_write}
//  stall              input   1           hold the ID/EX contents
//  flush              input   1           turn the ID/EX contents into a bubble
//  exmem_reg_write    input   1           EX/MEM writes rd
//  exmem_rd           input   REG_ADDR_W  EX/MEM destination index
//  exmem_result       input   XLEN        EX/MEM ALU result
//  memwb_reg_write    input   1           MEM/WB writes rd
//  memwb_rd           input   REG_ADDR_W  MEM/WB destination index
//  memwb_result       input   XLEN        MEM/WB writeback value
//  ex_valid           output  1           EX holds a real instruction
//  mux_1_out_alu_in   output  XLEN        ALU operand A (forwarded rs1)
//  mux_ex_out_alu_in  output  XLEN        ALU operand B (forwarded rs2, or the immediate)
//  ALUOp              output  4           registered ALU operation
//  ex_store_data      output  XLEN        forwarded rs2, for stores
//  ex_rd              output  REG_ADDR_W  registered rd
//  ex_ctrl            output  5           registered id_ctrl, gated by ex_valid
//  load_use_stall     output  1           request: stall IF/ID and flush this stage
// BEHAVIOUR
//  - Reset, applied at a clock edge, clears every register to 0.
//    Out of reset: ex_valid=0, ex_ctrl=0, ALUOp=0, ex_rd=0, and both operands=0.
//  - Reset asserted mid-stream discards the held instruction at the next edge; there is no partial state.
//  - Update priority at each edge: reset > flush > stall > load.
//    flush: ex_valid<=0, ctrl<=0; the data fields may also be zeroed.
//    stall: every register holds its value.
//    load: capture all id_* inputs; ex_valid<=id_valid.
//  - flush and stall asserted together: flush wins.
//  - Latency: 1 cycle ID->EX register. Forwarding and operand selection are combinational from the registers.
//  - Forward for rs1 (rs2 uses the same rules):
//    1. If exmem_reg_write && exmem_rd!=0 && exmem_rd==rs1, select exmem_result.
//    2. Else, if memwb_reg_write && memwb_rd!=0 && memwb_rd==rs1, select memwb_result.
//    3. Else, select the registered rs1_data.
//    EX/MEM beats MEM/WB when both match. x0 is never forwarded.
//  - mux_1_out_alu_in = fwd_rs1.
//    mux_ex_out_alu_in = alu_src ? imm : fwd_rs2.
//    ex_store_data = fwd_rs2 always.
//  - ex_ctrl = ex_valid ? ctrl_q : 0.
//  - load_use_stall = ex_valid & mem_read_q & (rd_q!=0) & (rd_q==id_rs1 | rd_q==id_rs2).
//    It is purely combinational.
//    The hazard unit asserts stall upstream and flush here; the next cycle load_use_stall drops.
//  - No arithmetic is done here. All fields pass at full width, with no extension.
// TESTING
//  1. Reset held 2 cycles with id_valid=1 -> ex_valid=0, ex_ctrl=0, both operands=0.
//  2. id_rs1_data=5, id_imm=7, alu_src=1, ALUOp=4'b0010, no forwarding hits
//     -> next cycle mux_1_out_alu_in=5, mux_ex_out_alu_in=7, ALUOp=2.
//  3. rs1=3, rs2=3; exmem_rd=3 (result 0xAA) and memwb_rd=3 (result 0xBB), both writing, alu_src=0
//     -> both operands=0xAA and ex_store_data=0xAA.
//  4. rs1=0, exmem_rd=0 with reg_write=1, exmem_result=0xFF, id_rs1_data=0 -> mux_1_out_alu_in=0.
//  5. EX holds a load with rd=4, ID has id_rs2=4 -> load_use_stall=1.
//     Then apply flush=1 and stall=1 -> next cycle ex_valid=0, ex_ctrl=0, load_use_stall=0.
//  6. stall=1 for 3 cycles while id_* changes -> all outputs stay constant.
//     Deassert stall -> the new id_* values are captured in 1 cycle.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage
// Brief    : ID/EX pipeline register with EX-stage operand forwarding and
//            load-use hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_operand_stage #(
    parameter int XLEN       = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [3:0]            id_alu_op,
    input  logic                  id_alu_src,
    input  logic [4:0]            id_ctrl,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_result,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       mux_1_out_alu_in,
    output logic [XLEN-1:0]       mux_ex_out_alu_in,
    output logic [3:0]            ALUOp,
    output logic [XLEN-1:0]       ex_store_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [4:0]            ex_ctrl,
    output logic                  load_use_stall
);

    // id_ctrl = {branch, mem_to_reg, mem_write, mem_read, reg_write}
    localparam int C_MEM_READ_BIT = 1;

    logic                  r_valid;
    logic [XLEN-1:0]       r_rs1_data;
    logic [XLEN-1:0]       r_rs2_data;
    logic [XLEN-1:0]       r_imm;
    logic [REG_ADDR_W-1:0] r_rs1;
    logic [REG_ADDR_W-1:0] r_rs2;
    logic [REG_ADDR_W-1:0] r_rd;
    logic [3:0]            r_alu_op;
    logic                  r_alu_src;
    logic [4:0]            r_ctrl;

    logic [XLEN-1:0]       w_fwd_rs1;
    logic [XLEN-1:0]       w_fwd_rs2;

    // Flush zeroes the data fields too, so a bubble is fully inert.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_valid    <= 1'b0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_alu_op   <= '0;
            r_alu_src  <= 1'b0;
            r_ctrl     <= '0;
        end else if (!stall) begin
            r_valid    <= id_valid;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_alu_op   <= id_alu_op;
            r_alu_src  <= id_alu_src;
            r_ctrl     <= id_ctrl;
        end
    end

    // EX/MEM has the younger result, so it wins; x0 is never forwarded.
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs1))
            w_fwd_rs1 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs1))
            w_fwd_rs1 = memwb_result;

        w_fwd_rs2 = r_rs2_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs2))
            w_fwd_rs2 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs2))
            w_fwd_rs2 = memwb_result;
    end

    assign ex_valid          = r_valid;
    assign mux_1_out_alu_in  = w_fwd_rs1;
    assign mux_ex_out_alu_in = r_alu_src ? r_imm : w_fwd_rs2;
    assign ex_store_data     = w_fwd_rs2;
    assign ALUOp             = r_alu_op;
    assign ex_rd             = r_rd;
    assign ex_ctrl           = r_valid ? r_ctrl : 5'd0;

    assign load_use_stall = r_valid && r_ctrl[C_MEM_READ_BIT] && (r_rd != '0)
                            && ((r_rd == id_rs1) || (r_rd == id_rs2));

endmodule
`default_nettype wire
